// File: rtl/proc_sequencer.sv
// proc_sequencer: instruction sequencer for the 32-bit processor.
// Fetches instruction words, holds them in the instruction register,
// strobes the datapath once per datapath instruction and resolves
// JMP/JZ/JNZ/HALT itself.
// Optional build macro: SEQ_SINGLE_STEP_EN adds a `step` input and a
// STEP state that parks the sequencer between instructions.
module proc_sequencer #(
    parameter int IMEM_AW    = 8,
    parameter int EXEC_DELAY = 4
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ir,
    output logic               exec_en,
    input  logic               zero_flag,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        instr_count
);

    // Sequencer states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;
`ifdef SEQ_SINGLE_STEP_EN
    localparam logic [2:0] S_STEP   = 3'd7;
`endif

    // Opcodes the sequencer handles itself
    localparam logic [4:0] OP_JMP  = 5'd12;
    localparam logic [4:0] OP_JZ   = 5'd13;
    localparam logic [4:0] OP_JNZ  = 5'd14;
    localparam logic [4:0] OP_HALT = 5'd15;

    localparam logic [3:0]         DELAY_LOAD = EXEC_DELAY[3:0];
    localparam logic [IMEM_AW-1:0] PC_ONE     = {{(IMEM_AW-1){1'b0}}, 1'b1};
    localparam logic [IMEM_AW-1:0] PC_ZERO    = '0;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [IMEM_AW-1:0] pc;
    logic [IMEM_AW-1:0] pc_pending;
    logic [IMEM_AW-1:0] pc_inc;
    logic [IMEM_AW-1:0] jump_target;
    logic [3:0]         wait_cnt;
    logic [4:0]         oper_type;
    logic               is_jump;
    logic               is_halt;
    logic               jump_taken;
    logic               start_accept;

    assign oper_type   = ir[31:27];
    assign jump_target = ir[IMEM_AW-1:0];
    assign pc_inc      = pc + PC_ONE;

    // Classify the held instruction and decide whether a branch is taken
    always_comb begin
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        jump_taken = 1'b0;
        case (oper_type)
            OP_JMP: begin
                is_jump    = 1'b1;
                jump_taken = 1'b1;
            end
            OP_JZ: begin
                is_jump    = 1'b1;
                jump_taken = zero_flag;
            end
            OP_JNZ: begin
                is_jump    = 1'b1;
                jump_taken = ~zero_flag;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
                is_jump    = 1'b0;
                is_halt    = 1'b0;
                jump_taken = 1'b0;
            end
        endcase
    end

    // Start is only honoured when the sequencer is parked
    assign start_accept = start && ((state == S_IDLE) || (state == S_HALTED));

    // Next-state selection for the sequencer FSM
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_next = S_HALTED;
                end else if (is_jump) begin
                    state_next = S_NEXT;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
`ifdef SEQ_SINGLE_STEP_EN
                state_next = S_STEP;
`else
                state_next = S_FETCH;
`endif
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_STEP: begin
                if (step) begin
                    state_next = S_FETCH;
                end
            end
`endif
            S_HALTED: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Program counter: the follow-on address is chosen in DECODE and only
    // committed in NEXT, so imem_addr never moves outside a fetch boundary
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pc         <= PC_ZERO;
            pc_pending <= PC_ZERO;
        end else begin
            if (start_accept) begin
                pc         <= PC_ZERO;
                pc_pending <= PC_ZERO;
            end else if (state == S_DECODE) begin
                if (is_jump && jump_taken) begin
                    pc_pending <= jump_target;
                end else begin
                    pc_pending <= pc_inc;
                end
            end else if (state == S_NEXT) begin
                pc <= pc_pending;
            end
        end
    end

    // Instruction register: loaded only on an accepted fetch
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ir <= 32'd0;
        end else if ((state == S_FETCH) && imem_ack) begin
            ir <= imem_rdata;
        end
    end

    // Execute settle counter: loaded on the strobe, counts down in WAIT
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wait_cnt <= 4'd0;
        end else if (state == S_EXEC) begin
            wait_cnt <= DELAY_LOAD;
        end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Completed-instruction counter; HALT never passes through NEXT
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            instr_count <= 16'd0;
        end else if (state == S_NEXT) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign exec_en   = (state == S_EXEC);
    assign halted    = (state == S_HALTED);
    assign busy      = (state != S_IDLE) && (state != S_HALTED);

endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed self-checking bench for proc_sequencer.
// Instruction memory is modelled with a configurable ack delay.
module tb_proc_sequencer;

    localparam int AW = 8;
`ifdef SEQ_SINGLE_STEP_EN
    localparam int SX = 1;
`else
    localparam int SX = 0;
`endif

    logic          clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic          step = 1'b1;
`endif
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = 32'd0;
    logic [31:0]   ir;
    logic          exec_en;
    logic          zero_flag = 1'b0;
    logic          busy;
    logic          halted;
    logic [15:0]   instr_count;

    int            tests_run = 0;
    int            tests_failed = 0;
    int            cycle = 0;
    int            base_cycle = 0;

    logic [31:0]   mem [0:255];
    int            ack_delay = 0;
    int            ack_wait = 0;
    logic          addr_changed = 1'b0;
    logic [AW-1:0] held_addr = '0;
    int            exec_q[$];
    int            fetch_q[$];
    int            exp_f[8];
    int            patch_addr = -1;
    logic [31:0]   patch_data = 32'd0;

    proc_sequencer #(.IMEM_AW(AW), .EXEC_DELAY(4)) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .start       (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .exec_en     (exec_en),
        .zero_flag   (zero_flag),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Instruction memory responder, driven on the falling edge
    always @(negedge clk) begin
        if (!imem_req) begin
            imem_ack = 1'b0;
            ack_wait = 0;
        end else begin
            if (ack_wait == 0) held_addr = imem_addr;
            else if (imem_addr != held_addr) addr_changed = 1'b1;
            if (ack_wait >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                fetch_q.push_back(int'(imem_addr));
                ack_wait   = 0;
            end else begin
                imem_ack = 1'b0;
                ack_wait++;
            end
        end
    end

    // Record the cycle of every execute strobe
    always @(negedge clk) begin
        if (exec_en) exec_q.push_back(cycle);
    end

    function automatic logic [31:0] dp_op(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic im,
                                          input logic [15:0] isrc);
        return {op, rd, rs1, im, isrc};
    endfunction

    function automatic logic [31:0] ctl_op(input logic [4:0] op, input logic [15:0] isrc);
        return {op, 11'd0, isrc};
    endfunction

    function automatic int fetch_at(input int i);
        if (i < fetch_q.size()) return fetch_q[i];
        return -1;
    endfunction

    function automatic int exec_at(input int i);
        if (i < exec_q.size()) return exec_q[i];
        return -1000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkFetchSeq(input string tag, input int n);
        checkOutput({tag, "_fetch_cnt"}, fetch_q.size(), n);
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_fetch%0d", tag, i), fetch_at(i), exp_f[i]);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"},    imem_req,    0);
        checkOutput({tag, "_addr"},   imem_addr,   0);
        checkOutput({tag, "_ir"},     ir,          0);
        checkOutput({tag, "_exec"},   exec_en,     0);
        checkOutput({tag, "_busy"},   busy,        0);
        checkOutput({tag, "_halted"}, halted,      0);
        checkOutput({tag, "_count"},  instr_count, 0);
    endtask

    // Pulse start, then wait (bounded) for HALTED; returns cycles from start
    task automatic applyStimulus(input int max_cycles, output int cyc);
        int n;
        exec_q.delete();
        fetch_q.delete();
        addr_changed = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        base_cycle = cycle;
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (patch_addr >= 0 && fetch_q.size() >= 1) begin
                mem[patch_addr] = patch_data;
                patch_addr = -1;
            end
        end while (!halted && n < max_cycles);
        if (!halted) checkOutput("halt_timeout", 0, 1);
        cyc = cycle - base_cycle;
    endtask

    logic [31:0] w_add, w_movi, w_halt;
    int          cyc;
    int          n;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        w_add  = dp_op(5'd2, 5'd0, 5'd4, 1'b0, {5'd5, 11'd0});
        w_movi = dp_op(5'd1, 5'd4, 5'd0, 1'b1, 16'd55);
        w_halt = ctl_op(5'd15, 16'd0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("rst");
        @(negedge clk);
        sys_rst = 1'b1;

        // ADD, MOVI, HALT with zero-wait memory
        mem[0] = w_add; mem[1] = w_movi; mem[2] = w_halt;
        applyStimulus(200, cyc);
        checkOutput("a_halt_cycle", cyc, 18 + 2 * SX);
        checkOutput("a_exec_cnt", exec_q.size(), 2);
        checkOutput("a_exec_first", exec_at(0) - base_cycle, 2);
        checkOutput("a_exec_period", exec_at(1) - exec_at(0), 8 + SX);
        checkOutput("a_count", instr_count, 2);
        checkOutput("a_ir", ir, w_halt);
        checkOutput("a_busy", busy, 0);
        checkOutput("a_halted", halted, 1);
        exp_f = '{0, 1, 2, 0, 0, 0, 0, 0};
        checkFetchSeq("a", 3);

        // JMP with junk upper bits, taken JZ, untaken JNZ (zero_flag=1)
        zero_flag = 1'b1;
        mem[0] = w_add; mem[1] = w_add; mem[2] = w_add;
        mem[3]    = ctl_op(5'd12, 16'hFF20);
        mem[8'h20] = ctl_op(5'd13, 16'h0310);
        mem[8'h10] = ctl_op(5'd14, 16'h0040);
        mem[8'h11] = w_halt;
        applyStimulus(300, cyc);
        checkOutput("b_halt_cycle", cyc, 35 + 6 * SX);
        checkOutput("b_exec_cnt", exec_q.size(), 3);
        checkOutput("b_count", instr_count, 8);
        exp_f = '{0, 1, 2, 3, 32'h20, 32'h10, 32'h11, 0};
        checkFetchSeq("b", 7);

        // Untaken JZ, taken JNZ (zero_flag=0)
        zero_flag = 1'b0;
        mem[0]     = ctl_op(5'd12, 16'h0005);
        mem[5]     = ctl_op(5'd13, 16'h0010);
        mem[6]     = ctl_op(5'd14, 16'h0030);
        mem[8'h30] = w_halt;
        applyStimulus(100, cyc);
        checkOutput("c_halt_cycle", cyc, 11 + 3 * SX);
        checkOutput("c_exec_cnt", exec_q.size(), 0);
        checkOutput("c_count", instr_count, 11);
        exp_f = '{0, 5, 6, 32'h30, 0, 0, 0, 0};
        checkFetchSeq("c", 4);

        // Memory ack delayed by 3 cycles
        ack_delay = 3;
        mem[0] = w_add; mem[1] = w_add; mem[2] = w_halt;
        applyStimulus(200, cyc);
        checkOutput("d_halt_cycle", cyc, 27 + 2 * SX);
        checkOutput("d_exec_first", exec_at(0) - base_cycle, 5);
        checkOutput("d_exec_period", exec_at(1) - exec_at(0), 11 + SX);
        checkOutput("d_addr_stable", addr_changed, 0);
        checkOutput("d_count", instr_count, 13);
        ack_delay = 0;

        // PC wrap from 0xFF to 0x00
        mem[0]     = ctl_op(5'd12, 16'h00FF);
        mem[8'hFF] = w_add;
        patch_addr = 0;
        patch_data = w_halt;
        applyStimulus(200, cyc);
        checkOutput("e_halt_cycle", cyc, 13 + 2 * SX);
        checkOutput("e_count", instr_count, 15);
        exp_f = '{0, 32'hFF, 0, 0, 0, 0, 0, 0};
        checkFetchSeq("e", 3);

        // Reset during WAIT, held 3 cycles
        mem[0] = w_add; mem[1] = w_halt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!exec_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("f_exec_seen", exec_en, 1);
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        #1;
        exec_q.delete();
        repeat (3) @(negedge clk);
        checkResetOutputs("f_rst");
        checkOutput("f_no_strobe", exec_q.size(), 0);
        sys_rst = 1'b1;
        applyStimulus(100, cyc);
        checkOutput("f_halt_cycle", cyc, 10 + SX);
        checkOutput("f_count", instr_count, 1);
        exp_f = '{0, 1, 0, 0, 0, 0, 0, 0};
        checkFetchSeq("f", 2);

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: parked in STEP until step pulses
        step = 1'b0;
        exec_q.delete();
        fetch_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("g_fetch_parked", fetch_q.size(), 1);
        checkOutput("g_busy_step", busy, 1);
        checkOutput("g_req_step", imem_req, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n = 0;
        while (!halted && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("g_halted", halted, 1);
        exp_f = '{0, 1, 0, 0, 0, 0, 0, 0};
        checkFetchSeq("g", 2);
        step = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
